parking_space_allocator: RTL
============================

# parking_space_allocator

Sequential control stage directly upstream of `calculate_new_capacity`. It owns the registered 8-spot occupancy bitmap and serves entry and exit requests one at a time. For each accepted request it drives a one-hot `park_location` into the XOR update stage and registers the returned `new_capacity` as the new occupancy. It also drives the entry gate and reports full, empty and free-count status.

## Interface
- `GATE_OPEN_CYCLES`, default 4: cycles `gate_open` stays high after an entry grant; legal range 1..255.

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `entry_req`  in  1  car at entry gate requests a spot; held by requester until accepted or rejected
- `exit_req`  in  1  car leaving; held until accepted or rejected
- `exit_location`  in  8  one-hot spot being vacated; qualified by `exit_req`
- `new_capacity`  in  8  result from `calculate_new_capacity` (`park_location ^ parking_capacity`)
- `req_ready`  out  1  FSM in IDLE; a request is taken on an edge where `req_ready` and a request are both high
- `park_location`  out  8  one-hot spot to toggle; nonzero only in UPDATE
- `parking_capacity`  out  8  occupancy bitmap, bit=1 occupied (registered)
- `grant_valid`  out  1  one-cycle pulse in UPDATE for an entry grant
- `reject`  out  1  one-cycle pulse: entry while full, or invalid exit
- `gate_open`  out  1  entry gate open
- `full`  out  1  `parking_capacity == 8'hFF`
- `empty`  out  1  `parking_capacity == 8'h00`
- `free_count`  out  4  popcount of `~parking_capacity`, 0..8

## Operation
- FSM states: IDLE, UPDATE, GATE.
- **IDLE** (`req_ready`=1):
  - If `exit_req` is high, the exit is handled; exit has priority over a simultaneous entry.
    - Valid exit: `exit_location` is exactly one-hot and that bit is set in `parking_capacity`. Register `park_location` <= `exit_location` and go to UPDATE.
    - Invalid exit: pulse `reject` for one cycle, stay in IDLE, leave state unchanged.
  - Otherwise, if `entry_req` is high:
    - When `full`: pulse `reject`, stay in IDLE.
    - Otherwise: register `park_location` <= the lowest-index clear bit of `parking_capacity` (one-hot) and go to UPDATE.
- **UPDATE**:
  - `parking_capacity` <= `new_capacity`.
  - `park_location` <= 0 at the end of the cycle.
  - Entry: pulse `grant_valid`, load the gate counter with `GATE_OPEN_CYCLES`, go to GATE.
  - Exit: go to IDLE.
- **GATE**: `gate_open`=1. Decrement the counter each cycle; go to IDLE on the cycle the counter reaches 1.
- Requests arriving outside IDLE are not queued. A requester holding its request is served on the next IDLE cycle.
- `park_location` of 0 makes the XOR stage pass capacity unchanged. No spurious update is possible outside UPDATE.
- `full`, `empty` and `free_count` are combinational from the `parking_capacity` register.

## Timing
- Reset values:
  - State IDLE; `parking_capacity` = 8'h00; `park_location` = 8'h00.
  - `grant_valid`, `reject`, `gate_open` all 0; gate counter 0.
  - Derived outputs after reset: `req_ready`=1, `empty`=1, `full`=0, `free_count`=8.
- Entry accepted at edge N:
  - UPDATE during cycle N+1.
  - New capacity visible from N+2.
  - `gate_open` high for cycles N+2 .. N+1+`GATE_OPEN_CYCLES`.
  - `req_ready` high again at N+2+`GATE_OPEN_CYCLES`.
- Exit accepted at edge N: UPDATE during cycle N+1; capacity updated and `req_ready` high from N+2.
- `reject` is high in the cycle after the sampling edge; FSM stays in IDLE. A still-held request is re-evaluated every IDLE cycle, so `reject` repeats while it is held.
- `rst` in any state takes effect at the next edge:
  - `gate_open` drops and any pending grant is abandoned.
  - Occupancy clears to 8'h00.

## Configuration
- `PARKING_STATS_EN` defined:
  - Adds output `entry_count` (16 bits), reset to 0.
  - Increments on each `grant_valid` pulse and saturates at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then one `entry_req` → `park_location`=8'h01 in UPDATE, `grant_valid` pulse, capacity 8'h01, `gate_open` for 4 cycles, `free_count`=7, `req_ready` back 6 cycles after acceptance.
- Eight back-to-back entries → capacity 8'hFF, `full`=1, `free_count`=0. Ninth entry → `reject` pulse, capacity stays 8'hFF, `gate_open` stays 0.
- From 8'hFF, exit with `exit_location`=8'h10 → capacity 8'hEF. Next entry gets `park_location`=8'h10, capacity returns to 8'hFF.
- Exits with `exit_location`=8'h03 and with a free spot (capacity 8'h01, location 8'h02) → `reject` pulse each time, capacity unchanged.
- `entry_req` and `exit_req` (8'h01) both high with capacity 8'h01 → exit served first (capacity 8'h00). The held entry is then granted 8'h01.
- Assert `rst` in the second GATE cycle → next cycle `gate_open`=0, capacity 8'h00, `req_ready`=1. With `PARKING_STATS_EN`, `entry_count`=0.

Source files
------------

// File: rtl/parking_space_allocator_if.sv
//------------------------------------------------------------------------------
// parking_space_allocator_if -- request, status and XOR-stage signals of the
// allocator; entry_count exists only when PARKING_STATS_EN is defined. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface parking_space_allocator_if;
  logic        entry_req;
  logic        exit_req;
  logic [7:0]  exit_location;
  logic [7:0]  new_capacity;
  logic        req_ready;
  logic [7:0]  park_location;
  logic [7:0]  parking_capacity;
  logic        grant_valid;
  logic        reject;
  logic        gate_open;
  logic        full;
  logic        empty;
  logic [3:0]  free_count;
`ifdef PARKING_STATS_EN
  logic [15:0] entry_count;
`endif

  modport master (
`ifdef PARKING_STATS_EN
    input  entry_count,
`endif
    output entry_req, exit_req, exit_location, new_capacity,
    input  req_ready, park_location, parking_capacity, grant_valid,
    input  reject, gate_open, full, empty, free_count
  );

  modport slave (
`ifdef PARKING_STATS_EN
    output entry_count,
`endif
    input  entry_req, exit_req, exit_location, new_capacity,
    output req_ready, park_location, parking_capacity, grant_valid,
    output reject, gate_open, full, empty, free_count
  );
endinterface

`default_nettype wire

// File: rtl/parking_space_allocator.sv
//------------------------------------------------------------------------------
// parking_space_allocator -- 8-spot occupancy FSM feeding calculate_new_capacity;
// define PARKING_STATS_EN to add the saturating entry_count output. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module parking_space_allocator #(
  parameter int GATE_OPEN_CYCLES = 4
) (
  input wire logic               clk,
  input wire logic               rst,
  parking_space_allocator_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_GATE   = 2'd2;
  localparam logic [7:0] GATE_LOAD = 8'(GATE_OPEN_CYCLES);

  logic [1:0] state_q, state_d;
  logic [7:0] park_q, park_d;
  logic [7:0] cap_q, cap_d;
  logic       is_entry_q, is_entry_d;
  logic       reject_q, reject_d;
  logic [7:0] gate_cnt_q, gate_cnt_d;

  logic [7:0] w_free_mask;
  logic [7:0] w_lowest_free;
  logic       w_full;
  logic       w_exit_valid;
  logic [3:0] w_free_count;
  logic       w_req_ready;
  logic       w_grant_valid;
  logic       w_gate_open;

  assign w_free_mask   = ~cap_q;
  // Two's-complement trick isolates the lowest clear spot as a one-hot mask.
  assign w_lowest_free = w_free_mask & (~w_free_mask + 8'd1);
  assign w_full        = (cap_q == 8'hFF);
  assign w_exit_valid  = (bus.exit_location != 8'h00) &&
                         ((bus.exit_location & (bus.exit_location - 8'd1)) == 8'h00) &&
                         ((bus.exit_location & cap_q) != 8'h00);

  always_comb begin
    w_free_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_free_count = w_free_count + {3'b000, w_free_mask[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      park_q     <= 8'h00;
      cap_q      <= 8'h00;
      is_entry_q <= 1'b0;
      reject_q   <= 1'b0;
      gate_cnt_q <= 8'h00;
    end else begin
      park_q     <= park_d;
      cap_q      <= cap_d;
      is_entry_q <= is_entry_d;
      reject_q   <= reject_d;
      gate_cnt_q <= gate_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    park_d     = park_q;
    cap_d      = cap_q;
    is_entry_d = is_entry_q;
    reject_d   = 1'b0;
    gate_cnt_d = gate_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.exit_req) begin
          if (w_exit_valid) begin
            park_d     = bus.exit_location;
            is_entry_d = 1'b0;
            state_d    = S_UPDATE;
          end else begin
            reject_d = 1'b1;
          end
        end else if (bus.entry_req) begin
          if (w_full) begin
            reject_d = 1'b1;
          end else begin
            park_d     = w_lowest_free;
            is_entry_d = 1'b1;
            state_d    = S_UPDATE;
          end
        end
      end
      S_UPDATE: begin
        cap_d  = bus.new_capacity;
        park_d = 8'h00;
        if (is_entry_q) begin
          gate_cnt_d = GATE_LOAD;
          state_d    = S_GATE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GATE: begin
        if (gate_cnt_q <= 8'd1) begin
          gate_cnt_d = 8'h00;
          state_d    = S_IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        park_d  = 8'h00;
      end
    endcase
  end

  always_comb begin
    w_req_ready   = (state_q == S_IDLE);
    w_grant_valid = (state_q == S_UPDATE) && is_entry_q;
    w_gate_open   = (state_q == S_GATE);
  end

`ifdef PARKING_STATS_EN
  logic [15:0] entry_count_q, entry_count_d;

  always_comb begin
    entry_count_d = entry_count_q;
    if (w_grant_valid && (entry_count_q != 16'hFFFF)) begin
      entry_count_d = entry_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_count_q <= 16'h0000;
    end else begin
      entry_count_q <= entry_count_d;
    end
  end

  assign bus.entry_count = entry_count_q;
`endif

  assign bus.req_ready        = w_req_ready;
  assign bus.park_location    = park_q;
  assign bus.parking_capacity = cap_q;
  assign bus.grant_valid      = w_grant_valid;
  assign bus.reject           = reject_q;
  assign bus.gate_open        = w_gate_open;
  assign bus.full             = w_full;
  assign bus.empty            = (cap_q == 8'h00);
  assign bus.free_count       = w_free_count;

endmodule

`default_nettype wire
